// File: rtl/fru_pla_cfg_loader.sv
// fru_pla_cfg_loader
//   Configuration writer for the FRU PLA. The loader takes a stream of config
//   words followed by one XOR checksum word. It builds the AND-plane and
//   OR-plane programming bits in a shadow register. If the checksum matches,
//   the shadow is committed to the active planes in a single cycle, so the PLA
//   never sees a partial or corrupt configuration.
//
//   Config vector V = {OrPlane, AndPlane}. Word k carries V[k*CFG_W +: CFG_W],
//   and word 0 is sent first. The checksum word is the XOR of all NWORDS data
//   words exactly as sent, including any padding bits.
//
//   Optional feature macro: FRU_CFG_READBACK_EN. It adds a readback port that
//   streams the active words followed by their XOR.
//
// Ports
//   Clk        in   rising-edge clock
//   Rst        in   synchronous active-high reset
//   CfgStart   in   1-cycle pulse: begin or restart a load (has priority)
//   CfgValid   in   CfgData is valid
//   CfgReady   out  loader accepts a word (registered, 1 in LOAD/CHECK)
//   CfgData    in   config or checksum word
//   CfgDone    out  1-cycle pulse: a commit happened
//   CfgErr     out  sticky checksum error, cleared by CfgStart or Rst
//   CfgActive  out  a valid config has been committed since reset
//   AndPlane   out  [m*2*IN+i] = minterm m uses Trigger[i],
//                   [m*2*IN+IN+i] = minterm m uses ~Trigger[i]
//   OrPlane    out  [o*MINTERMS+m] = FruSelect[o] ORs minterm m
//   DbgState   out  current FSM state (0 IDLE, 1 LOAD, 2 CHECK)
//   RbReq      in   (readback build) request a readback
//   RbValid    out  (readback build) RbData valid
//   RbData     out  (readback build) active word or the trailing XOR
//
// Handshake: a beat occurs on a rising edge where CfgValid & CfgReady are both
// high. CfgReady does not depend on CfgValid. CfgValid may drop between beats
// for any number of cycles.
module fru_pla_cfg_loader #(
  parameter int INPUT_SIZE  = 2,
  parameter int OUTPUT_SIZE = 4,
  parameter int MINTERMS    = 4,
  parameter int CFG_W       = 8
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              CfgStart,
  input  logic                              CfgValid,
  output logic                              CfgReady,
  input  logic [CFG_W-1:0]                  CfgData,
  output logic                              CfgDone,
  output logic                              CfgErr,
  output logic                              CfgActive,
  output logic [MINTERMS*2*INPUT_SIZE-1:0]  AndPlane,
  output logic [OUTPUT_SIZE*MINTERMS-1:0]   OrPlane,
`ifdef FRU_CFG_READBACK_EN
  input  logic                              RbReq,
  output logic                              RbValid,
  output logic [CFG_W-1:0]                  RbData,
`endif
  output logic [1:0]                        DbgState
);

  localparam int AND_W  = MINTERMS * 2 * INPUT_SIZE;
  localparam int OR_W   = OUTPUT_SIZE * MINTERMS;
  localparam int V_W    = AND_W + OR_W;
  localparam int NWORDS = (V_W + CFG_W - 1) / CFG_W;
  localparam int SH_W   = NWORDS * CFG_W;
  localparam int CNT_W  = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CFG_W-1:0]   acc;
  logic [SH_W-1:0]    shadow;
  logic               beat;

  assign beat     = CfgValid & CfgReady;
  assign DbgState = state;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      shadow    <= '0;
      AndPlane  <= '0;
      OrPlane   <= '0;
      CfgReady  <= 1'b0;
      CfgDone   <= 1'b0;
      CfgErr    <= 1'b0;
      CfgActive <= 1'b0;
    end else begin
      CfgDone <= 1'b0;
      if (CfgStart) begin
        // Start wins over any beat in the same cycle. That beat is consumed
        // and dropped, and a half-built shadow is discarded.
        state    <= LOAD;
        cnt      <= '0;
        acc      <= '0;
        shadow   <= '0;
        CfgErr   <= 1'b0;
        CfgReady <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            CfgReady <= 1'b0;
          end
          LOAD: begin
            CfgReady <= 1'b1;
            if (beat) begin
              for (int k = 0; k < NWORDS; k++) begin
                if (cnt == CNT_W'(k)) shadow[k*CFG_W +: CFG_W] <= CfgData;
              end
              acc <= acc ^ CfgData;
              cnt <= cnt + 1'b1;
              if (cnt == CNT_W'(NWORDS - 1)) state <= CHECK;
            end
          end
          CHECK: begin
            if (beat) begin
              CfgReady <= 1'b0;
              state    <= IDLE;
              if (CfgData == acc) begin
                // Both planes load on the same edge, so the PLA never sees
                // a mix of old and new bits.
                {OrPlane, AndPlane} <= shadow[V_W-1:0];
                CfgActive           <= 1'b1;
                CfgDone             <= 1'b1;
              end else begin
                CfgErr <= 1'b1;
              end
            end else begin
              CfgReady <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            CfgReady <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FRU_CFG_READBACK_EN
  localparam int RB_W = $clog2(NWORDS + 2);

  logic [SH_W-1:0]  activeVec;
  logic [CFG_W-1:0] activeXor;
  logic [CFG_W-1:0] rbNext;
  logic [RB_W-1:0]  rbIdx;

  always_comb begin
    activeVec            = '0;
    activeVec[V_W-1:0]   = {OrPlane, AndPlane};
    activeXor            = '0;
    for (int k = 0; k < NWORDS; k++) activeXor = activeXor ^ activeVec[k*CFG_W +: CFG_W];
  end

  // rbIdx selects the next word to present. An index of NWORDS selects the
  // trailing XOR.
  always_comb begin
    rbNext = activeXor;
    for (int k = 0; k < NWORDS; k++) begin
      if (rbIdx == RB_W'(k)) rbNext = activeVec[k*CFG_W +: CFG_W];
    end
  end

  // RbValid doubles as the busy flag. A request is accepted only while it is low.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      RbValid <= 1'b0;
      RbData  <= '0;
      rbIdx   <= '0;
    end else if (!RbValid) begin
      if (RbReq) begin
        RbValid <= 1'b1;
        RbData  <= activeVec[CFG_W-1:0];
        rbIdx   <= RB_W'(1);
      end
    end else if (rbIdx == RB_W'(NWORDS + 1)) begin
      RbValid <= 1'b0;
      RbData  <= '0;
      rbIdx   <= '0;
    end else begin
      RbData <= rbNext;
      rbIdx  <= rbIdx + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fru_pla_cfg_loader.sv
module tb_fru_pla_cfg_loader;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        CfgStart = 1'b0;
  logic        CfgValid = 1'b0;
  logic        CfgReady;
  logic [7:0]  CfgData = '0;
  logic        CfgDone;
  logic        CfgErr;
  logic        CfgActive;
  logic [15:0] AndPlane;
  logic [15:0] OrPlane;
  logic [1:0]  DbgState;
`ifdef FRU_CFG_READBACK_EN
  logic        RbReq = 1'b0;
  logic        RbValid;
  logic [7:0]  RbData;
`endif

  always #5 Clk = ~Clk;

  fru_pla_cfg_loader dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .CfgStart  (CfgStart),
    .CfgValid  (CfgValid),
    .CfgReady  (CfgReady),
    .CfgData   (CfgData),
    .CfgDone   (CfgDone),
    .CfgErr    (CfgErr),
    .CfgActive (CfgActive),
    .AndPlane  (AndPlane),
    .OrPlane   (OrPlane),
`ifdef FRU_CFG_READBACK_EN
    .RbReq     (RbReq),
    .RbValid   (RbValid),
    .RbData    (RbData),
`endif
    .DbgState  (DbgState)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        eRdy;
    logic [1:0]  eSt;
    logic        eDone;
    logic        eErr;
    logic        eAct;
    logic [15:0] eAnd;
    logic [15:0] eOr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic start, input logic valid, input logic [7:0] data,
                     input logic eRdy, input logic [1:0] eSt, input logic eDone, input logic eErr,
                     input logic eAct, input logic [15:0] eAnd, input logic [15:0] eOr);
    vec_t v;
    v.rst = rst; v.start = start; v.valid = valid; v.data = data;
    v.eRdy = eRdy; v.eSt = eSt; v.eDone = eDone; v.eErr = eErr;
    v.eAct = eAct; v.eAnd = eAnd; v.eOr = eOr;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic start, input logic valid, input logic [7:0] data);
    Rst = rst; CfgStart = start; CfgValid = valid; CfgData = data;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".rdy"},   {31'd0, CfgReady},  {31'd0, v.eRdy});
    check({tag, ".state"}, {30'd0, DbgState},  {30'd0, v.eSt});
    check({tag, ".done"},  {31'd0, CfgDone},   {31'd0, v.eDone});
    check({tag, ".err"},   {31'd0, CfgErr},    {31'd0, v.eErr});
    check({tag, ".act"},   {31'd0, CfgActive}, {31'd0, v.eAct});
    check({tag, ".and"},   {16'd0, AndPlane},  {16'd0, v.eAnd});
    check({tag, ".or"},    {16'd0, OrPlane},   {16'd0, v.eOr});
  endtask

  task automatic send_word(input logic [7:0] d);
    drive(0, 0, 1, d);
    step();
    drive(0, 0, 0, 8'h00);
  endtask

  // ---------------- test ----------------
  initial begin
    // reset, then a valid word in IDLE which must be ignored
    add(1,0,0,8'h00, 0,0,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'hAA, 0,0,0,0,0,16'h0000,16'h0000);
    // good load, back-to-back
    add(0,1,0,8'h00, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'h21, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'h84, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'hF0, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'h0F, 1,2,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'h5A, 0,0,1,0,1,16'h8421,16'h0FF0);
    add(0,0,0,8'h00, 0,0,0,0,1,16'h8421,16'h0FF0);
    // bad checksum after a fresh reset
    add(1,0,0,8'h00, 0,0,0,0,0,16'h0000,16'h0000);
    add(0,1,0,8'h00, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'h21, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'h84, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'hF0, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'h0F, 1,2,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'h5B, 0,0,0,1,0,16'h0000,16'h0000);
    add(0,0,0,8'h00, 0,0,0,1,0,16'h0000,16'h0000);
    add(0,1,0,8'h00, 1,1,0,0,0,16'h0000,16'h0000);
    // same good data, CfgValid every other cycle
    add(0,0,1,8'h21, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,0,8'h00, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'h84, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,0,8'h00, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'hF0, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,0,8'h00, 1,1,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'h0F, 1,2,0,0,0,16'h0000,16'h0000);
    add(0,0,0,8'h00, 1,2,0,0,0,16'h0000,16'h0000);
    add(0,0,1,8'h5A, 0,0,1,0,1,16'h8421,16'h0FF0);
    add(0,0,0,8'h00, 0,0,0,0,1,16'h8421,16'h0FF0);
    // restart mid-load keeps active planes, single commit of the new data
    add(0,1,0,8'h00, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h21, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h84, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,1,0,8'h00, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h11, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h22, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h33, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h44, 1,2,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h44, 0,0,1,0,1,16'h2211,16'h4433);
    add(0,0,0,8'h00, 0,0,0,0,1,16'h2211,16'h4433);
    // beat coincident with CfgStart is dropped
    add(0,1,1,8'hFF, 1,1,0,0,1,16'h2211,16'h4433);
    add(0,0,1,8'h21, 1,1,0,0,1,16'h2211,16'h4433);
    add(0,0,1,8'h84, 1,1,0,0,1,16'h2211,16'h4433);
    add(0,0,1,8'hF0, 1,1,0,0,1,16'h2211,16'h4433);
    add(0,0,1,8'h0F, 1,2,0,0,1,16'h2211,16'h4433);
    add(0,0,1,8'h5A, 0,0,1,0,1,16'h8421,16'h0FF0);
    // CfgStart on the checksum beat: no commit, fresh load follows
    add(0,1,0,8'h00, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h11, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h22, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h33, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h44, 1,2,0,0,1,16'h8421,16'h0FF0);
    add(0,1,1,8'h44, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h11, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h22, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h33, 1,1,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h44, 1,2,0,0,1,16'h8421,16'h0FF0);
    add(0,0,1,8'h44, 0,0,1,0,1,16'h2211,16'h4433);
    // Rst while in CHECK clears everything including active planes
    add(0,1,0,8'h00, 1,1,0,0,1,16'h2211,16'h4433);
    add(0,0,1,8'h21, 1,1,0,0,1,16'h2211,16'h4433);
    add(0,0,1,8'h84, 1,1,0,0,1,16'h2211,16'h4433);
    add(0,0,1,8'hF0, 1,1,0,0,1,16'h2211,16'h4433);
    add(0,0,1,8'h0F, 1,2,0,0,1,16'h2211,16'h4433);
    add(1,0,1,8'h5A, 0,0,0,0,0,16'h0000,16'h0000);
    add(0,0,0,8'h00, 0,0,0,0,0,16'h0000,16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].valid, vecs[i].data);
      step();
      check_all($sformatf("vec%0d", i), vecs[i]);
    end
    drive(0, 0, 0, 8'h00);

    // hand sequence: gapped load, bounded wait for CfgDone, planes via exp_q
    begin
      logic [7:0] words[5];
      int waited;
      words[0] = 8'h21; words[1] = 8'h84; words[2] = 8'hF0; words[3] = 8'h0F; words[4] = 8'h5A;
      drive(0, 1, 0, 8'h00);
      step();
      drive(0, 0, 0, 8'h00);
      for (int k = 0; k < 4; k++) begin
        send_word(words[k]);
        repeat (k) step();
      end
      drive(0, 0, 1, words[4]);
      step();
      drive(0, 0, 0, 8'h00);
      waited = 0;
      while (!CfgDone && waited < 10) begin
        step();
        waited++;
      end
      check("seq.done_seen", {31'd0, CfgDone}, 32'd1);
      check("seq.done_latency", waited, 0);
      exp_q.push_back(16'h8421);
      exp_q.push_back(16'h0FF0);
      check("seq.and", {16'd0, AndPlane}, {16'd0, exp_q.pop_front()});
      check("seq.or",  {16'd0, OrPlane},  {16'd0, exp_q.pop_front()});
      step();
      check("seq.done_pulse", {31'd0, CfgDone}, 32'd0);
    end

`ifdef FRU_CFG_READBACK_EN
    // readback of the committed config, with a second request mid-window
    exp_q.push_back(16'h0021);
    exp_q.push_back(16'h0084);
    exp_q.push_back(16'h00F0);
    exp_q.push_back(16'h000F);
    exp_q.push_back(16'h005A);
    check("rb.idle", {31'd0, RbValid}, 32'd0);
    RbReq = 1'b1;
    step();
    RbReq = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rb.valid%0d", k), {31'd0, RbValid}, 32'd1);
      check($sformatf("rb.data%0d", k), {24'd0, RbData}, {16'd0, exp_q.pop_front()});
      RbReq = (k == 1);
      step();
      RbReq = 1'b0;
    end
    check("rb.end", {31'd0, RbValid}, 32'd0);
    step();
    check("rb.no_retrigger", {31'd0, RbValid}, 32'd0);
`endif

    check("final.q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
